mandala_frame_scheduler: RTL
============================

// Module: mandala_frame_scheduler
// PURPOSE
//  Frame-synchronous controller for the mandala pattern datapath. Owns the
//  animation state: phase counter, palette index and pattern mode. Updates
//  them only at the vsync rising edge, so the display never tears.
//  Adds run/pause/single-step control from two asynchronous pushbuttons.
//  Sits between ui_in and the pattern/colour logic; takes vsync from hvsync_generator.
// PARAMETERS
//  SYNC_STAGES  2  synchroniser depth for btn_pause/btn_next (>=2)
//  PALETTES     6  number of palettes; palette wraps PALETTES-1 -> 0
//  PHASE_W      8  width of phase counter
// PORTS
//  clk        in   1        pixel clock
//  rst_n      in   1        reset, asynchronous, active-low
//  vsync      in   1        vertical sync level from sync generator, active-high
//  btn_pause  in   1        async pushbutton, level; press toggles run/pause
//  btn_next   in   1        async pushbutton, level; press steps one phase while paused
//  speed      in   2        frames per phase step = 2**speed (1,2,4,8)
//  mode_req   in   2        requested pattern mode
//  phase      out  PHASE_W  animation phase fed to the angle comparators
//  palette    out  3        colour palette index, 0..PALETTES-1
//  mode       out  2        active pattern mode
//  frame_tick out  1        one-cycle pulse, once per frame
//  paused     out  1        1 = PAUSE state
// BEHAVIOUR
//  Reset: all outputs 0, state RUN, frame_cnt 0, pending flags clear,
//   synchroniser flops 0, vsync_q 0. Reset clears everything immediately,
//   including mid-frame.
//  Inputs: btn_* pass through SYNC_STAGES flops, then rising-edge detect
//   (one pulse per press; held buttons never repeat). vsync is
//   registered into vsync_q; edge = vsync & ~vsync_q.
//  Frame edge: at the clock edge where edge=1, register in parallel:
//   - frame_tick=1; all updates below appear the cycle after vsync is
//     first sampled high.
//   - mode<=mode_req.
//   - state change and phase step.
//   frame_tick is 0 on all other cycles.
//  Pending flags: pause_req is set by a btn_pause edge. next_req is set
//   by a btn_next edge only while in PAUSE. Both are consumed and cleared
//   at the next frame edge. A press during an already-pending request
//   does nothing extra (requests do not count).
//  Precedence: if pause and next edges arrive on the same cycle, the pause
//   edge is taken and the next edge is dropped. At a frame edge with
//   pause_req set, the state toggles and next_req is discarded.
//  FSM, evaluated at frame edge only:
//   - RUN: pause_req -> PAUSE (no phase step this frame). Otherwise
//     frame_cnt steps: if frame_cnt >= 2**speed-1, step phase and clear
//     frame_cnt; else increment frame_cnt.
//   - PAUSE: pause_req -> RUN (frame_cnt<=0, no step). Else if next_req,
//     step phase once and stay in PAUSE. Else hold.
//  speed is sampled at each frame edge. The >= compare makes a speed
//   decrease take effect at once with no long wait.
//  Phase step: phase<=phase+1, wrapping 2**PHASE_W-1 -> 0. On that wrap,
//   palette<=palette+1, wrapping PALETTES-1 -> 0.
//  paused = (state==PAUSE), registered.
//  Between frame edges, no output changes except frame_tick falling.
// TESTING
//  1 Reset: rst_n low mid-run -> phase/palette/mode/paused/frame_tick 0
//    with no clock edge; after release state is RUN.
//  2 speed=0, 3 vsync pulses -> phase 1,2,3, frame_tick one cycle each.
//    speed=2, 8 pulses -> phase +2. speed 3->0 with frame_cnt=5 -> step
//    on the next frame.
//  3 phase preset path: 256 steps at speed=0 -> phase 0, palette 1.
//    6*256 steps -> palette back to 0.
//  4 btn_pause held 10 clocks mid-frame -> paused=1 only at the next
//    frame_tick. Phase is frozen over 5 frames. btn_next pulse -> phase+1
//    at the next frame only. Two next presses in one frame -> +1.
//  5 mode_req 0->3 mid-frame -> mode stays 0 until the frame_tick cycle,
//    then 3.
//  6 btn_pause and btn_next rising together while paused -> resumes RUN,
//    no extra step. btn_next while in RUN -> ignored.

Source files
------------

// File: rtl/mandala_frame_scheduler.sv
// mandala_frame_scheduler: frame-synchronous animation state (phase,
// palette, mode) with run/pause/single-step pushbutton control.
module mandala_frame_scheduler #(
  parameter int SYNC_STAGES = 2,
  parameter int PALETTES    = 6,
  parameter int PHASE_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vsync,
  input  logic               btn_pause,
  input  logic               btn_next,
  input  logic [1:0]         speed,
  input  logic [1:0]         mode_req,
  output logic [PHASE_W-1:0] phase,
  output logic [2:0]         palette,
  output logic [1:0]         mode,
  output logic               frame_tick,
  output logic               paused
);
  typedef enum logic {RUN, PAUSE} state_e;
  localparam logic [2:0] PAL_LAST = 3'(PALETTES - 1);

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] psync_q, psync_d;
  logic [SYNC_STAGES-1:0] nsync_q, nsync_d;
  logic                   pbtn_q, pbtn_d;
  logic                   nbtn_q, nbtn_d;
  logic                   vsync_q, vsync_d;
  logic                   preq_q, preq_d;
  logic                   nreq_q, nreq_d;
  logic [2:0]             fcnt_q, fcnt_d;
  logic [PHASE_W-1:0]     phase_q, phase_d;
  logic [2:0]             pal_q, pal_d;
  logic [1:0]             mode_q, mode_d;
  logic                   tick_q, tick_d;
  logic                   paused_q, paused_d;
  logic                   p_edge, n_edge, f_edge, step;
  logic [2:0]             cnt_lim;

  always_comb begin
    unique case (speed)
      2'd0:    cnt_lim = 3'd0;
      2'd1:    cnt_lim = 3'd1;
      2'd2:    cnt_lim = 3'd3;
      default: cnt_lim = 3'd7;
    endcase
  end

  always_comb begin
    psync_d = {psync_q[SYNC_STAGES-2:0], btn_pause};
    nsync_d = {nsync_q[SYNC_STAGES-2:0], btn_next};
    pbtn_d  = psync_q[SYNC_STAGES-1];
    nbtn_d  = nsync_q[SYNC_STAGES-1];
    vsync_d = vsync;
    p_edge  = psync_q[SYNC_STAGES-1] & ~pbtn_q;
    // a simultaneous pause press wins; the next press is dropped
    n_edge  = nsync_q[SYNC_STAGES-1] & ~nbtn_q & ~p_edge;
    f_edge  = vsync & ~vsync_q;

    state_d = state_q;
    fcnt_d  = fcnt_q;
    mode_d  = mode_q;
    tick_d  = f_edge;
    step    = 1'b0;
    preq_d  = preq_q | p_edge;
    nreq_d  = nreq_q | (n_edge & (state_q == PAUSE));

    if (f_edge) begin
      mode_d = mode_req;
      preq_d = p_edge;
      nreq_d = n_edge & (state_q == PAUSE);
      if (preq_q) begin
        state_d = (state_q == RUN) ? PAUSE : RUN;
        if (state_q == PAUSE) fcnt_d = '0;
      end else if (state_q == RUN) begin
        if (fcnt_q >= cnt_lim) begin
          step   = 1'b1;
          fcnt_d = '0;
        end else begin
          fcnt_d = fcnt_q + 3'd1;
        end
      end else begin
        step = nreq_q;
      end
    end

    phase_d = phase_q;
    pal_d   = pal_q;
    if (step) begin
      phase_d = phase_q + 1'b1;
      if (&phase_q)
        pal_d = (pal_q == PAL_LAST) ? 3'd0 : pal_q + 3'd1;
    end
    paused_d = (state_d == PAUSE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      psync_q  <= '0;
      nsync_q  <= '0;
      pbtn_q   <= 1'b0;
      nbtn_q   <= 1'b0;
      vsync_q  <= 1'b0;
      preq_q   <= 1'b0;
      nreq_q   <= 1'b0;
      fcnt_q   <= '0;
      phase_q  <= '0;
      pal_q    <= '0;
      mode_q   <= '0;
      tick_q   <= 1'b0;
      paused_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      psync_q  <= psync_d;
      nsync_q  <= nsync_d;
      pbtn_q   <= pbtn_d;
      nbtn_q   <= nbtn_d;
      vsync_q  <= vsync_d;
      preq_q   <= preq_d;
      nreq_q   <= nreq_d;
      fcnt_q   <= fcnt_d;
      phase_q  <= phase_d;
      pal_q    <= pal_d;
      mode_q   <= mode_d;
      tick_q   <= tick_d;
      paused_q <= paused_d;
    end
  end

  assign phase      = phase_q;
  assign palette    = pal_q;
  assign mode       = mode_q;
  assign frame_tick = tick_q;
  assign paused     = paused_q;
endmodule
